// File: rtl/spi_pkt_ctrl_v2.sv
// SPI packet controller, parametrised successor.
// Decodes byte packets (TYPE, LEN_H, LEN_L, payload) from the SPI slave, drives a bank of
// frequency-synthesizer channels, packs multi-byte samples into the sample FIFO and answers
// FIFO-space / status queries.
// Optional feature: define CTRL_CHECKSUM_EN to expect a trailing XOR checksum byte after every
// FIFO_DATA payload; a mismatch sets the chk_err sticky bit.
module spi_pkt_ctrl_v2 #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SPACE_W   = 13,
  parameter int unsigned NUM_SYNTH = 2,
  parameter int unsigned SEL_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_tsx_start,
  input  logic [7:0]         spi_rx_data,
  input  logic               spi_rx_stb,
  output logic [7:0]         spi_tx_data,
  input  logic [SPACE_W-1:0] fifo_space_free,
  input  logic               fifo_full,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wr,
  output logic [SEL_W-1:0]   synth_sel,
  output logic [7:0]         synth_data,
  output logic               synth_wr_divr,
  output logic               synth_wr_divf,
  output logic               busy,
  output logic               pkt_err
);

  localparam int unsigned NBYTES   = DATA_W / 8;
  // Byte index within a sample; 2 bits covers up to 4-byte samples.
  localparam logic [1:0]  LAST_IDX = 2'(NBYTES - 1);

  localparam logic [7:0] TypeGetSpace  = 8'h01;
  localparam logic [7:0] TypeSetFreq   = 8'h02;
  localparam logic [7:0] TypeFifoData  = 8'h03;
  localparam logic [7:0] TypeGetStatus = 8'h04;

  typedef enum logic [3:0] {
    StIdle,
    StType,
    StLenH,
    StLenL,
    StSpaceL,
    StFreqCh,
    StFreqDivr,
    StFreqDivf,
    StFifo,
    StDrain
`ifdef CTRL_CHECKSUM_EN
    , StChk
`endif
  } state_e;

  state_e              state;
  logic [7:0]          pkt_type;
  logic [7:0]          len_h;
  logic [15:0]         sample_cnt;
  logic [1:0]          byte_idx;
  logic [DATA_W-1:0]   sample;
  logic [SPACE_W-1:0]  space_snap;
  logic                overflow;
  logic                bad_type;
  logic                chk_err;
`ifdef CTRL_CHECKSUM_EN
  logic [7:0]          chk_acc;
`endif

  logic [DATA_W-1:0]   sample_next;
  logic [7:0]          space_hi;

  // Sample register with the new byte shifted in at the bottom (MSB byte arrives first).
  assign sample_next = DATA_W'({sample, spi_rx_data});
  // Upper bits of the live free-space count, zero-padded to a byte.
  assign space_hi    = 8'(fifo_space_free >> 8);

  assign busy    = (state != StIdle);
  assign pkt_err = overflow | bad_type | chk_err;

`ifndef CTRL_CHECKSUM_EN
  assign chk_err = 1'b0;
`endif

  // Packet decoder FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      pkt_type      <= '0;
      len_h         <= '0;
      sample_cnt    <= '0;
      byte_idx      <= '0;
      sample        <= '0;
      space_snap    <= '0;
      overflow      <= 1'b0;
      bad_type      <= 1'b0;
      spi_tx_data   <= '0;
      fifo_data     <= '0;
      fifo_wr       <= 1'b0;
      synth_sel     <= '0;
      synth_data    <= '0;
      synth_wr_divr <= 1'b0;
      synth_wr_divf <= 1'b0;
`ifdef CTRL_CHECKSUM_EN
      chk_err       <= 1'b0;
      chk_acc       <= '0;
`endif
    end else begin
      fifo_wr       <= 1'b0;
      synth_wr_divr <= 1'b0;
      synth_wr_divf <= 1'b0;

      if (spi_tsx_start) begin
        // New transaction aborts whatever was in flight, including a partial sample.
        state       <= StType;
        spi_tx_data <= 8'hA5;
        sample      <= '0;
        byte_idx    <= '0;
`ifdef CTRL_CHECKSUM_EN
        chk_acc     <= '0;
`endif
      end else if (spi_rx_stb) begin
        case (state)
          StType: begin
            pkt_type    <= spi_rx_data;
            spi_tx_data <= 8'h00;
            state       <= StLenH;
          end
          StLenH: begin
            len_h <= spi_rx_data;
            state <= StLenL;
          end
          StLenL: begin
            case (pkt_type)
              TypeGetSpace: begin
                space_snap  <= fifo_space_free;
                spi_tx_data <= space_hi;
                state       <= StSpaceL;
              end
              TypeSetFreq: begin
                state <= StFreqCh;
              end
              TypeFifoData: begin
                if ({len_h, spi_rx_data} == 16'd0) begin
                  state <= StIdle;
                end else begin
                  sample_cnt <= {len_h, spi_rx_data};
                  byte_idx   <= '0;
                  state      <= StFifo;
`ifdef CTRL_CHECKSUM_EN
                  chk_acc    <= '0;
`endif
                end
              end
              TypeGetStatus: begin
                spi_tx_data <= {5'b0, chk_err, bad_type, overflow};
                overflow    <= 1'b0;
                bad_type    <= 1'b0;
`ifdef CTRL_CHECKSUM_EN
                chk_err     <= 1'b0;
`endif
                state       <= StIdle;
              end
              default: begin
                bad_type <= 1'b1;
                state    <= StDrain;
              end
            endcase
          end
          StSpaceL: begin
            spi_tx_data <= space_snap[7:0];
            state       <= StIdle;
          end
          StFreqCh: begin
            if ({24'd0, spi_rx_data} >= NUM_SYNTH) begin
              bad_type <= 1'b1;
              state    <= StDrain;
            end else begin
              synth_sel <= SEL_W'(spi_rx_data);
              state     <= StFreqDivr;
            end
          end
          StFreqDivr: begin
            synth_data    <= spi_rx_data;
            synth_wr_divr <= 1'b1;
            state         <= StFreqDivf;
          end
          StFreqDivf: begin
            synth_data    <= spi_rx_data;
            synth_wr_divf <= 1'b1;
            state         <= StIdle;
          end
          StFifo: begin
            sample      <= sample_next;
            spi_tx_data <= fifo_space_free[7:0];
`ifdef CTRL_CHECKSUM_EN
            chk_acc     <= chk_acc ^ spi_rx_data;
`endif
            if (byte_idx == LAST_IDX) begin
              byte_idx  <= '0;
              fifo_data <= sample_next;
              // A full FIFO drops the sample but the payload is still consumed.
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr <= 1'b1;
              end
              if (sample_cnt != 16'd0) begin
                sample_cnt <= sample_cnt - 16'd1;
              end
              if (sample_cnt <= 16'd1) begin
`ifdef CTRL_CHECKSUM_EN
                state <= StChk;
`else
                state <= StIdle;
`endif
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
`ifdef CTRL_CHECKSUM_EN
          StChk: begin
            // Samples already written stay written; only the sticky flag records the error.
            if (spi_rx_data != chk_acc) begin
              chk_err <= 1'b1;
            end
            state <= StIdle;
          end
`endif
          default: begin
            // StIdle and StDrain ignore received bytes.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pkt_ctrl_v2.sv
// Directed, table-driven bench for spi_pkt_ctrl_v2 (default parameters).
module tb_spi_pkt_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_tsx_start;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_stb;
  logic [7:0]  spi_tx_data;
  logic [12:0] fifo_space_free;
  logic        fifo_full;
  logic [15:0] fifo_data;
  logic        fifo_wr;
  logic [3:0]  synth_sel;
  logic [7:0]  synth_data;
  logic        synth_wr_divr;
  logic        synth_wr_divf;
  logic        busy;
  logic        pkt_err;

  int passed = 0;
  int total  = 0;

  spi_pkt_ctrl_v2 #(
    .DATA_W   (16),
    .SPACE_W  (13),
    .NUM_SYNTH(2),
    .SEL_W    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .spi_tsx_start  (spi_tsx_start),
    .spi_rx_data    (spi_rx_data),
    .spi_rx_stb     (spi_rx_stb),
    .spi_tx_data    (spi_tx_data),
    .fifo_space_free(fifo_space_free),
    .fifo_full      (fifo_full),
    .fifo_data      (fifo_data),
    .fifo_wr        (fifo_wr),
    .synth_sel      (synth_sel),
    .synth_data     (synth_data),
    .synth_wr_divr  (synth_wr_divr),
    .synth_wr_divf  (synth_wr_divf),
    .busy           (busy),
    .pkt_err        (pkt_err)
  );

  always #5 clk = ~clk;

  // Busy state after the last FIFO payload byte: still waiting for the checksum byte if enabled.
`ifdef CTRL_CHECKSUM_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  localparam logic [12:0] S = 13'h1234;
  localparam logic [12:0] F = 13'h0056;

  typedef struct {
    bit          tsx;
    bit          stb;
    logic [7:0]  d;
    bit          full;
    logic [12:0] space;
    logic [7:0]  tx;
    bit          busy;
    bit          err;
    bit          fwr;
    logic [15:0] fd;
    bit          dr;
    bit          df;
    logic [3:0]  sel;
    logic [7:0]  sd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit tsx, bit stb, logic [7:0] d, bit full, logic [12:0] space,
                              logic [7:0] tx, bit bsy, bit err, bit fwr, logic [15:0] fd,
                              bit dr, bit df, logic [3:0] sel, logic [7:0] sd);
    vecs.push_back('{tsx, stb, d, full, space, tx, bsy, err, fwr, fd, dr, df, sel, sd});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    spi_tsx_start = 1'b0;
    spi_rx_stb = 1'b0;
    spi_rx_data = 8'h00;
    fifo_full = 1'b0;
    fifo_space_free = S;

    // 1: GET_SPACE, snapshot not re-sampled, IDLE ignores bytes
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h01, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h00, 0, S, 8'h12, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h00, 0, 13'h0FFF, 8'h34, 0, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'hAA, 0, S, 8'h34, 0, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    // 2: SET_FREQ channel 1
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h02, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd0, 8'h00);
    add(0, 1, 8'h01, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h00);
    add(0, 1, 8'h05, 0, S, 8'h00, 1, 0, 0, 16'h0000, 1, 0, 4'd1, 8'h05);
    add(0, 1, 8'h2A, 0, S, 8'h00, 0, 0, 0, 16'h0000, 0, 1, 4'd1, 8'h2A);
    // 3: FIFO_DATA, two 16-bit samples
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h02, 0, S, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hAB, 0, F, 8'h56, 1, 0, 0, 16'h0000, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hCD, 0, F, 8'h56, 1, 0, 1, 16'hABCD, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h12, 0, F, 8'h56, 1, 0, 0, 16'hABCD, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h34, 0, F, 8'h56, BC, 0, 1, 16'h1234, 0, 0, 4'd1, 8'h2A);
`ifdef CTRL_CHECKSUM_EN
    add(0, 1, 8'h40, 0, F, 8'h56, 0, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
`endif
    // FIFO_DATA with LEN=0 returns straight to IDLE
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 0, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    // 4: LEN=3, FIFO full during the second sample, then GET_STATUS
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h11, 0, F, 8'h56, 1, 0, 0, 16'h1234, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h22, 0, F, 8'h56, 1, 0, 1, 16'h1122, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h33, 1, F, 8'h56, 1, 0, 0, 16'h1122, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h44, 1, F, 8'h56, 1, 1, 0, 16'h3344, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h55, 0, F, 8'h56, 1, 1, 0, 16'h3344, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h66, 0, F, 8'h56, BC, 1, 1, 16'h5566, 0, 0, 4'd1, 8'h2A);
`ifdef CTRL_CHECKSUM_EN
    add(0, 1, 8'h77, 0, F, 8'h56, 0, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
`endif
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h04, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h01, 0, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    // 5: unknown type, then out-of-range channel; both drain until tsx_start
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h07, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h02, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h05, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h02, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h05, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h77, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h04, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h02, 0, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    // 6: abort mid-sample (tsx_start wins over a same-cycle stb), partial byte discarded
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h01, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hAB, 0, F, 8'h56, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(1, 1, 8'h12, 0, F, 8'hA5, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h01, 0, S, 8'h00, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hCD, 0, F, 8'h56, 1, 0, 0, 16'h5566, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hEF, 0, F, 8'h56, BC, 0, 1, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
`ifdef CTRL_CHECKSUM_EN
    add(0, 1, 8'h22, 0, F, 8'h56, 0, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    // Wrong checksum: sample stays written, chk_err raised and reported as status bit 2
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h03, 0, S, 8'h00, 1, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h01, 0, S, 8'h00, 1, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h01, 0, F, 8'h56, 1, 0, 0, 16'hCDEF, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h02, 0, F, 8'h56, 1, 0, 1, 16'h0102, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'hFF, 0, F, 8'h56, 0, 1, 0, 16'h0102, 0, 0, 4'd1, 8'h2A);
    add(1, 0, 8'h00, 0, S, 8'hA5, 1, 1, 0, 16'h0102, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h04, 0, S, 8'h00, 1, 1, 0, 16'h0102, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h00, 1, 1, 0, 16'h0102, 0, 0, 4'd1, 8'h2A);
    add(0, 1, 8'h00, 0, S, 8'h04, 0, 0, 0, 16'h0102, 0, 0, 4'd1, 8'h2A);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset tx", spi_tx_data, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset pkt_err", pkt_err, 1'b0);
    check("reset strobes", {fifo_wr, synth_wr_divr, synth_wr_divf}, 3'b000);
    check("reset fifo_data", fifo_data, 16'h0000);
    check("reset synth", {synth_sel, synth_data}, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      spi_tsx_start   = vecs[i].tsx;
      spi_rx_stb      = vecs[i].stb;
      spi_rx_data     = vecs[i].d;
      fifo_full       = vecs[i].full;
      fifo_space_free = vecs[i].space;
      @(negedge clk);
      spi_tsx_start = 1'b0;
      spi_rx_stb    = 1'b0;
      check($sformatf("v%0d tx", i), spi_tx_data, vecs[i].tx);
      check($sformatf("v%0d busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d pkt_err", i), pkt_err, vecs[i].err);
      check($sformatf("v%0d fifo_wr", i), fifo_wr, vecs[i].fwr);
      check($sformatf("v%0d fifo_data", i), fifo_data, vecs[i].fd);
      check($sformatf("v%0d divr", i), synth_wr_divr, vecs[i].dr);
      check($sformatf("v%0d divf", i), synth_wr_divf, vecs[i].df);
      check($sformatf("v%0d synth_sel", i), synth_sel, vecs[i].sel);
      check($sformatf("v%0d synth_data", i), synth_data, vecs[i].sd);
      // Strobes must have dropped after exactly one cycle.
      @(negedge clk);
      check($sformatf("v%0d strobes low", i), {fifo_wr, synth_wr_divr, synth_wr_divf}, 3'b000);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_pkt_ctrl_v2.md
Name: spi_pkt_ctrl_v2

Overview:
Parametrised successor to the SPI packet controller. Decodes byte packets from the SPI slave and drives N frequency-synthesizer channels. Assembles multi-byte IQ samples into the sample FIFO and answers FIFO-space and status queries. Sits between spi.v and the sample FIFO / synthesizer bank.

Parameters:
DATA_W, 16, FIFO sample width in bits; multiple of 8, range 8..32; sent MSB byte first.
SPACE_W, 13, width of fifo_space_free; 9..16.
NUM_SYNTH, 2, number of synthesizer channels; 1..16.
SEL_W, 4, width of synth_sel; must be at least clog2(NUM_SYNTH).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
spi_tsx_start  in  1  one-cycle pulse: chip-select asserted, new transaction
spi_rx_data  in  8  received byte
spi_rx_stb  in  1  one-cycle pulse: spi_rx_data valid; at most 1 in 3 cycles
spi_tx_data  out  8  byte shifted out during the next SPI byte
fifo_space_free  in  SPACE_W  free FIFO entries
fifo_full  in  1  FIFO full
fifo_data  out  DATA_W  sample to FIFO
fifo_wr  out  1  one-cycle FIFO write strobe
synth_sel  out  SEL_W  target synthesizer channel
synth_data  out  8  DIVR/DIVF value
synth_wr_divr  out  1  one-cycle DIVR write strobe
synth_wr_divf  out  1  one-cycle DIVF write strobe
busy  out  1  high in any state except IDLE
pkt_err  out  1  OR of the sticky status bits

Behaviour:
- Reset: state=IDLE; all outputs 0; sticky bits 0; counters 0.
- All strobe outputs default to 0 every cycle, so each is high for exactly one cycle.
- Packet format: TYPE, LEN_H, LEN_L, then payload. LEN is 16-bit.
- spi_tsx_start in any state:
  - state goes to TYPE and spi_tx_data=0xA5.
  - A partial sample is discarded.
  - This abort has priority over spi_rx_stb in the same cycle.
- TYPE: on stb, latch the type and set spi_tx_data=0x00.
- LEN_H then LEN_L: on each stb, latch the length byte.
- On the LEN_L stb, dispatch by type:
  - 0x01 GET_SPACE: snapshot fifo_space_free; spi_tx_data={zero-pad, space[SPACE_W-1:8]}; go to SPACE_L. LEN is ignored.
  - 0x02 SET_FREQ: go to FREQ_CH. LEN is ignored.
  - 0x03 FIFO_DATA: if LEN=0, go to IDLE; otherwise go to FIFO with the sample counter set to LEN and the byte index set to 0.
  - 0x04 GET_STATUS: spi_tx_data={5'b0, chk_err, bad_type, overflow}; clear all sticky bits in that same cycle; go to IDLE.
  - Any other type: set bad_type; go to DRAIN.
- SPACE_L: on stb, spi_tx_data=space snapshot[7:0]; go to IDLE. The snapshot is not re-sampled.
- FREQ_CH: on stb, latch the channel. If channel >= NUM_SYNTH, set bad_type and go to DRAIN; otherwise set synth_sel=channel and go to FREQ_DIVR.
- FREQ_DIVR: on stb, synth_data=byte, synth_wr_divr=1 next cycle, go to FREQ_DIVF.
- FREQ_DIVF: on stb, synth_data=byte, synth_wr_divf=1, go to IDLE.
- FIFO state:
  - Each stb shifts the byte into the sample register, MSB first.
  - On the (DATA_W/8)-th byte, fifo_data=sample and the sample counter decrements.
  - If fifo_full=0, pulse fifo_wr. If fifo_full=1, drop the sample with no fifo_wr, set overflow, and keep consuming bytes; there is no early exit.
  - spi_tx_data=fifo_space_free[7:0] on every stb.
  - When the counter reaches 0, go to IDLE, or to CHK when CTRL_CHECKSUM_EN is defined.
- DRAIN: ignore bytes until spi_tsx_start.
- IDLE: ignore stb.
- Counter wraps are impossible: the decrement is gated by counter != 0.

Optional Feature:
Macro: CTRL_CHECKSUM_EN.
- Defined:
  - FIFO_DATA packets carry one trailing byte, received in state CHK, equal to the XOR of all payload bytes.
  - On a mismatch, set chk_err. On a match, do nothing.
  - Either way, go to IDLE.
  - Samples are already written and are not retracted.
- Undefined: there is no CHK state, the chk_err bit reads 0, and no trailing byte is expected.

Test Plan:
1. Reset, then tsx_start -> spi_tx_data=0xA5, busy=1. Then bytes 01,00,00 with fifo_space_free=13'h1234 -> spi_tx_data=0x12, then 0x34 after the next stb, then IDLE.
2. Bytes 02,00,00,01,0x05,0x2A -> synth_sel=1; synth_wr_divr pulses once with synth_data=0x05; synth_wr_divf pulses once with 0x2A.
3. DATA_W=16, bytes 03,00,02,AB,CD,12,34 -> two fifo_wr pulses with 16'hABCD then 16'h1234, then IDLE.
4. FIFO_DATA with LEN=3 and fifo_full=1 during the 2nd sample -> 2 writes, overflow set, pkt_err=1. GET_STATUS then returns 0x01 and clears pkt_err.
5. Type 0x07, or SET_FREQ with channel 5 when NUM_SYNTH=2 -> no strobes, bad_type set, bytes ignored until tsx_start.
6. tsx_start after the first byte of a sample mid-FIFO_DATA -> no fifo_wr, state=TYPE. With CTRL_CHECKSUM_EN and a wrong checksum byte -> chk_err=1.
